text_overlay_ctrl: RTL and testbench
====================================

# text_overlay_ctrl

Text-overlay sequencer that shares one 5x8 glyph character generator across a ROWS x COLS character buffer and scans it in step with the VGA pixel counters. It owns the text buffer (write port plus hardware clear) and drives the generator's character code, glyph column and glyph row. It registers the generator's pixel into an overlay pixel aligned to the video pipeline. It sits between the VGA timing generator and the colour mux.

## Interface
- COLS, 16, characters per text row
- ROWS, 4, text rows
- ORIGIN_X, 64, first active pixel column of the text box
- ORIGIN_Y, 48, first active line of the text box
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one character this cycle
- wr_col  in  $clog2(COLS)  write column
- wr_row  in  $clog2(ROWS)  write row
- wr_char  in  8  ASCII code
- clr  in  1  start hardware clear (1-cycle pulse)
- busy  out  1  clear in progress
- hcount  in  11  current pixel column
- vcount  in  11  current line
- video_on  in  1  active-video flag
- char_sel  out  8  code to glyph generator
- glyph_x  out  3  glyph column; 0 = leftmost
- glyph_y  out  3  glyph row; 0 = top
- glyph_pixel  in  1  combinational generator output
- pixel_out  out  1  overlay pixel
- pixel_valid  out  1  video_on delayed to align with pixel_out

## Operation
- Buffer: COLS*ROWS bytes, each reset to 8'd32 (space).
- A write with wr_en high in IDLE updates the cell at the next edge. Out-of-range wr_col/wr_row writes are dropped.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr. The clear index starts at 0.
  - CLEAR writes space to cell[idx] each cycle, for COLS*ROWS cycles, then returns to IDLE.
  - busy = (state == CLEAR).
  - clr during CLEAR restarts idx at 0.
  - wr_en during CLEAR is dropped.
  - clr together with wr_en in IDLE: clr wins and the write is dropped.
- Cell geometry: 6 wide (5 glyph columns + 1 blank gap), 8 tall. Box spans x in [ORIGIN_X, ORIGIN_X+6*COLS) and y in [ORIGIN_Y, ORIGIN_Y+8*ROWS).
- Horizontal position:
  - A sub-column counter (0..5) and a column counter are loaded to 0 when hcount == ORIGIN_X.
  - Both advance once per clock; hcount must step by 1 per clock within a line.
  - No divider is used.
- Vertical position: dy = vcount - ORIGIN_Y; glyph_y = dy[2:0]; row = dy >> 3.
- Outside the box, or in the gap column: char_sel = 8'd32, glyph_x = 0, and the pixel is forced to 0.
- Display reads are never blocked by writes or by a clear. A cell shows its new code from the first scan after the write edge.

## Timing
- Stage 1 (edge after hcount/vcount sample): char_sel, glyph_x, glyph_y, in_box and gap are registered. glyph_pixel is valid in the same cycle.
- Stage 2: pixel_out = in_box & ~gap & glyph_pixel. pixel_valid = video_on delayed 2.
- Latency is 2 clocks, from hcount to pixel_out/pixel_valid.
- Reset values: busy 0, char_sel 8'd32, glyph_x 0, glyph_y 0, pixel_out 0, pixel_valid 0, state IDLE, all cells space.
- Reset mid-clear aborts the clear; every cell returns to space anyway.
- Clear duration is exactly COLS*ROWS cycles (64 by default). busy falls on the edge after cell COLS*ROWS-1 is written.

## Configuration
- TEXT_CURSOR_EN defined:
  - Adds inputs cur_col and cur_row (same widths as wr_col and wr_row).
  - Adds a 6-bit frame counter, incremented when hcount==0 && vcount==0.
  - pixel_out inside the cursor cell, including its gap column, is inverted while frame counter bit 5 is 1.
  - Reset clears the frame counter.
- TEXT_CURSOR_EN undefined: none of the above exists.

## Structure
- text_overlay_pkg: CELL_W=6, CELL_H=8, GLYPH_W=5, SPACE_CHAR=8'd32, and the state enum {IDLE, CLEAR}.
- Sub-module text_buffer: owns storage, the write port and the clear FSM. It has a combinational read port indexed by (row, col).
- The glyph generator stays outside this block and is connected through char_sel, glyph_x, glyph_y and glyph_pixel.

## Test plan
- Reset, then scan the full box -> every char_sel is 32 and pixel_out is 0 throughout.
- Write 'A' (8'd65) to (0,0); scan line vcount=48 -> char_sel=65 with glyph_y=0 at hcount 64..68, and pixel_out is 0 at hcount 69 (gap). pixel_out follows glyph_pixel, 2 cycles late.
- Write 'Z' to (15,3) -> char_sel=90 at hcount 154..158 on lines 72..79. At hcount 160 (outside box), pixel_out=0.
- Fill all cells, then pulse clr -> busy is high for exactly 64 cycles and all cells read 32 afterwards. A wr_en issued during busy has no effect.
- clr and wr_en in the same cycle -> the write is dropped and the clear completes. Asserting rst_n=0 mid-clear gives busy=0 and all cells reading space.
- With TEXT_CURSOR_EN defined, cursor at (2,1) -> pixels in x 76..81, y 56..63 are inverted only while frame counter bit 5 is 1.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants and state type for the text overlay sequencer.
package text_overlay_pkg;

  localparam int CELL_W  = 6;
  localparam int CELL_H  = 8;
  localparam int GLYPH_W = 5;

  localparam logic [7:0] SPACE_CHAR = 8'd32;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/text_overlay_ctrl_text_buffer.sv
// Character buffer: write port, hardware clear FSM, async read port.
module text_buffer
  import text_overlay_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [7:0]              wr_char,
  input  logic                    clr,
  output logic                    busy,
  input  logic [$clog2(COLS)-1:0] rd_col,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [7:0]              rd_char
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);

  localparam logic [CW:0]   COLS_L = (CW+1)'(COLS);
  localparam logic [RW:0]   ROWS_L = (RW+1)'(ROWS);
  localparam logic [AW-1:0] LAST   = AW'(N - 1);

  logic [7:0]    mem [N];
  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_ok = ({1'b0, wr_col} < COLS_L) &&
                 ({1'b0, wr_row} < ROWS_L);
  assign wr_addr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

  assign busy    = (state == CLEAR);
  assign rd_char = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // clr has priority over a same-cycle write; writes never land mid-clear
  always_comb begin
    state_n = state;
    idx_n   = idx;
    we      = 1'b0;
    waddr   = wr_addr;
    wdata   = wr_char;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          idx_n   = '0;
        end else if (wr_en && wr_ok) begin
          we = 1'b1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = idx;
        wdata = SPACE_CHAR;
        if (clr) begin
          idx_n = '0;
        end else if (idx == LAST) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= SPACE_CHAR;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay sequencer feeding a shared 5x8 glyph generator.
// Optional blinking cursor: define TEXT_CURSOR_EN.
module text_overlay_ctrl
  import text_overlay_pkg::*;
#(
  parameter int COLS     = 16,
  parameter int ROWS     = 4,
  parameter int ORIGIN_X = 64,
  parameter int ORIGIN_Y = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [7:0]              wr_char,
  input  logic                    clr,
  output logic                    busy,
  input  logic [10:0]             hcount,
  input  logic [10:0]             vcount,
  input  logic                    video_on,
`ifdef TEXT_CURSOR_EN
  input  logic [$clog2(COLS)-1:0] cur_col,
  input  logic [$clog2(ROWS)-1:0] cur_row,
`endif
  output logic [7:0]              char_sel,
  output logic [2:0]              glyph_x,
  output logic [2:0]              glyph_y,
  input  logic                    glyph_pixel,
  output logic                    pixel_out,
  output logic                    pixel_valid
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [10:0] X0 = 11'(ORIGIN_X);
  localparam logic [10:0] X1 = 11'(ORIGIN_X + CELL_W * COLS);
  localparam logic [10:0] Y0 = 11'(ORIGIN_Y);
  localparam logic [10:0] Y1 = 11'(ORIGIN_Y + CELL_H * ROWS);

  localparam logic [2:0] SUB_LAST = 3'(CELL_W - 1);
  localparam logic [2:0] GAP_SUB  = 3'(GLYPH_W);

  logic [2:0]    sub_q, sub_c;
  logic [CW-1:0] col_q, col_c;
  logic [10:0]   dy;
  logic [RW-1:0] row;
  logic          in_box, gap, show;
  logic [7:0]    rd_char;
  logic          in_box_q, gap_q, vid_q;
  logic          cur_inv;

  // counters restart at the box edge, so col/sub need no divider
  always_comb begin
    sub_c = sub_q;
    col_c = col_q;
    if (hcount == X0) begin
      sub_c = '0;
      col_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      col_q <= '0;
    end else if (sub_c == SUB_LAST) begin
      sub_q <= '0;
      col_q <= col_c + 1'b1;
    end else begin
      sub_q <= sub_c + 3'd1;
      col_q <= col_c;
    end
  end

  assign dy     = vcount - Y0;
  assign row    = RW'(dy >> 3);
  assign in_box = (hcount >= X0) && (hcount < X1) &&
                  (vcount >= Y0) && (vcount < Y1);
  assign gap    = (sub_c == GAP_SUB);
  assign show   = in_box && !gap;

  text_buffer #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_row  (wr_row),
    .wr_char (wr_char),
    .clr     (clr),
    .busy    (busy),
    .rd_col  (col_c),
    .rd_row  (row),
    .rd_char (rd_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_sel <= SPACE_CHAR;
      glyph_x  <= '0;
      glyph_y  <= '0;
      in_box_q <= 1'b0;
      gap_q    <= 1'b0;
      vid_q    <= 1'b0;
    end else begin
      char_sel <= show ? rd_char : SPACE_CHAR;
      glyph_x  <= show ? sub_c : 3'd0;
      glyph_y  <= in_box ? 3'(dy) : 3'd0;
      in_box_q <= in_box;
      gap_q    <= gap;
      vid_q    <= video_on;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic [5:0] frame_q;
  logic       cur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      cur_q   <= 1'b0;
    end else begin
      if (hcount == 11'd0 && vcount == 11'd0)
        frame_q <= frame_q + 6'd1;
      cur_q <= in_box && (col_c == cur_col) && (row == cur_row);
    end
  end

  assign cur_inv = cur_q & frame_q[5];
`else
  assign cur_inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_out   <= (in_box_q & ~gap_q & glyph_pixel) ^ cur_inv;
      pixel_valid <= vid_q;
    end
  end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed self-checking bench for text_overlay_ctrl.
module tb_text_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [1:0]  wr_row;
  logic [7:0]  wr_char;
  logic        clr;
  logic        busy;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        video_on;
  logic [3:0]  cur_col;
  logic [1:0]  cur_row;
  logic [7:0]  char_sel;
  logic [2:0]  glyph_x;
  logic [2:0]  glyph_y;
  logic        glyph_pixel;
  logic        pixel_out;
  logic        pixel_valid;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_mem [64];
  int         fc = 0;

  always #5 clk = ~clk;

  // stand-in glyph generator: blank for space, pattern otherwise
  assign glyph_pixel = (char_sel != 8'd32) &&
                       (char_sel[glyph_x] ^ glyph_y[0]);

  text_overlay_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_char     (wr_char),
    .clr         (clr),
    .busy        (busy),
    .hcount      (hcount),
    .vcount      (vcount),
    .video_on    (video_on),
`ifdef TEXT_CURSOR_EN
    .cur_col     (cur_col),
    .cur_row     (cur_row),
`endif
    .char_sel    (char_sel),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_pixel (glyph_pixel),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid)
  );

  function automatic bit in_box(int h, int v);
    return h >= 64 && h < 160 && v >= 48 && v < 80;
  endfunction

  function automatic logic [7:0] exp_char(int h, int v);
    if (!in_box(h, v) || (h - 64) % 6 == 5) return 8'd32;
    return exp_mem[((v - 48) / 8) * 16 + (h - 64) / 6];
  endfunction

  function automatic logic [2:0] exp_gx(int h, int v);
    if (!in_box(h, v) || (h - 64) % 6 == 5) return 3'd0;
    return 3'((h - 64) % 6);
  endfunction

  function automatic logic exp_px(int h, int v);
    logic [7:0] code;
    int sub;
    logic base, cur;
    code = exp_char(h, v);
    sub  = in_box(h, v) ? (h - 64) % 6 : 0;
    base = in_box(h, v) && sub != 5 && code != 8'd32 &&
           (code[sub] ^ ((v - 48) % 2 == 1));
    cur = 1'b0;
`ifdef TEXT_CURSOR_EN
    cur = in_box(h, v) && (h - 64) / 6 == int'(cur_col) &&
          (v - 48) / 8 == int'(cur_row) && fc[5];
`endif
    return base ^ cur;
  endfunction

  task automatic scan_line(input int v);
    int h1 = -1;
    int h2 = -1;
    logic vo1 = 1'b0;
    logic vo2 = 1'b0;
    logic vo;
    for (int h = 60; h <= 167; h++) begin
      @(negedge clk);
      if (h1 >= 0) begin
        n_chk++;
        if (char_sel !== exp_char(h1, v))
          $display("FAIL char_sel h=%0d v=%0d got %0d exp %0d",
                   h1, v, char_sel, exp_char(h1, v));
        else n_pass++;
        n_chk++;
        if (glyph_x !== exp_gx(h1, v))
          $display("FAIL glyph_x h=%0d v=%0d got %0d exp %0d",
                   h1, v, glyph_x, exp_gx(h1, v));
        else n_pass++;
        if (in_box(h1, v)) begin
          n_chk++;
          if (glyph_y !== 3'((v - 48) % 8))
            $display("FAIL glyph_y h=%0d v=%0d got %0d exp %0d",
                     h1, v, glyph_y, (v - 48) % 8);
          else n_pass++;
        end
      end
      if (h2 >= 0) begin
        n_chk++;
        if (pixel_out !== exp_px(h2, v))
          $display("FAIL pixel_out h=%0d v=%0d got %b exp %b",
                   h2, v, pixel_out, exp_px(h2, v));
        else n_pass++;
        n_chk++;
        if (pixel_valid !== vo2)
          $display("FAIL pixel_valid h=%0d v=%0d got %b exp %b",
                   h2, v, pixel_valid, vo2);
        else n_pass++;
      end
      vo  = (h % 3 != 0);
      h2  = h1;
      vo2 = vo1;
      h1  = h;
      vo1 = vo;
      hcount   = 11'(h);
      vcount   = 11'(v);
      video_on = vo;
    end
    @(negedge clk);
    hcount   = 11'd1000;
    vcount   = 11'd1000;
    video_on = 1'b0;
  endtask

  task automatic scan_box();
    for (int v = 47; v <= 80; v++) scan_line(v);
  endtask

  task automatic model_blank();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'd32;
  endtask

  task automatic write_cell(input int c, input int r, input int ch);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_col  = 4'(c);
    wr_row  = 2'(r);
    wr_char = 8'(ch);
    @(negedge clk);
    wr_en = 1'b0;
    exp_mem[r * 16 + c] = 8'(ch);
  endtask

  task automatic do_clear(input bit same_wr, input int inj_at);
    int cnt = 0;
    bit done = 0;
    @(negedge clk);
    clr = 1'b1;
    if (same_wr) begin
      wr_en   = 1'b1;
      wr_col  = 4'd5;
      wr_row  = 2'd2;
      wr_char = 8'd81;
    end
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      clr   = 1'b0;
      wr_en = 1'b0;
      if (busy) begin
        cnt++;
        if (cnt == inj_at) begin
          wr_en   = 1'b1;
          wr_col  = 4'd0;
          wr_row  = 2'd0;
          wr_char = 8'd88;
        end
      end else begin
        done = 1;
      end
    end
    n_chk++;
    if (cnt !== 64)
      $display("FAIL busy_len got %0d exp 64", cnt);
    else n_pass++;
    model_blank();
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_col   = '0;
    wr_row   = '0;
    wr_char  = '0;
    clr      = 1'b0;
    hcount   = 11'd1000;
    vcount   = 11'd1000;
    video_on = 1'b1;
    cur_col  = 4'd2;
    cur_row  = 2'd1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, char_sel, glyph_x, glyph_y, pixel_out, pixel_valid}
        !== {1'b0, 8'd32, 3'd0, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_outs got %b %0d %0d %0d %b %b exp 0 32 0 0 0 0",
               busy, char_sel, glyph_x, glyph_y, pixel_out, pixel_valid);
    else n_pass++;
    rst_n = 1'b1;
    video_on = 1'b0;
    model_blank();
    fc = 0;
  endtask

  task automatic test_blank_scan();
    scan_box();
  endtask

  task automatic test_write_a();
    write_cell(0, 0, 65);
    scan_line(48);
    scan_line(49);
  endtask

  task automatic test_write_z();
    write_cell(15, 3, 90);
    scan_line(72);
    scan_line(79);
    scan_line(80);
  endtask

  task automatic test_clear();
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_col  = 4'(i % 16);
      wr_row  = 2'(i / 16);
      wr_char = 8'(65 + i % 26);
      exp_mem[i] = 8'(65 + i % 26);
      @(negedge clk);
    end
    wr_en = 1'b0;
    scan_line(48);
    scan_line(61);
    scan_line(79);
    do_clear(1'b0, 30);
    scan_box();
  endtask

  task automatic test_back_to_back();
    do_clear(1'b1, 0);
    scan_line(64);
    scan_line(65);
  endtask

  task automatic test_reset_mid_clear();
    write_cell(3, 1, 66);
    write_cell(9, 2, 67);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0)
      $display("FAIL rst_mid_clear_busy got %b exp 0", busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_blank();
    fc = 0;
    write_cell(3, 1, 70);
    scan_box();
  endtask

`ifdef TEXT_CURSOR_EN
  task automatic test_cursor();
    write_cell(2, 1, 65);
    scan_line(56);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      hcount = 11'd0;
      vcount = 11'd0;
      @(negedge clk);
      hcount = 11'd1000;
      vcount = 11'd1000;
      fc++;
    end
    scan_line(55);
    scan_line(56);
    scan_line(63);
    scan_line(64);
  endtask
`endif

  initial begin
    test_reset();
    test_blank_scan();
    test_write_a();
    test_write_z();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
`ifdef TEXT_CURSOR_EN
    test_cursor();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
